// File: rtl/sram_ctrl.sv
// Word-to-half-word bridge from the CPU memory port to an external asynchronous 16-bit SRAM.
// Each 32-bit request becomes one or two SETUP/ACCESS phases; completion is a one-cycle mem_ready.
module sram_ctrl #(
   parameter int ADDR_WIDTH  = 18,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  re,
   input  logic [3:0]            we,
   input  logic [29:0]           addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic                  mem_ready,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [15:0]           sram_dout,
   output logic                  sram_doe,
   input  logic [15:0]           sram_din,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic                  sram_lb_n,
   output logic                  sram_ub_n
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP_LO,
      ACC_LO,
      SETUP_HI,
      ACC_HI,
      DONE
   } state_t;

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      wcnt_q, wcnt_d;
   logic                  is_wr_q, is_wr_d;
   logic [3:0]            be_q, be_d;
   logic [ADDR_WIDTH-2:0] haddr_q, haddr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  ready_q, ready_d;
   logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
   logic [15:0]           dout_q, dout_d;
   logic                  doe_q, doe_d;
   logic                  ce_n_q, ce_n_d;
   logic                  oe_n_q, oe_n_d;
   logic                  we_n_q, we_n_d;
   logic                  lb_n_q, lb_n_d;
   logic                  ub_n_q, ub_n_d;

   logic accept, acc_last, need_lo, need_hi;
   logic lo_ph, hi_ph, acc_ph, active;

   // Upper word-address bits fall outside the SRAM and simply alias.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr[29:ADDR_WIDTH-1];

   always_comb begin
      accept   = (state_q == IDLE) && (re || (|we));
      acc_last = (wcnt_q == CNT_LAST);

      is_wr_d = is_wr_q;
      be_d    = be_q;
      haddr_d = haddr_q;
      wdata_d = wdata_q;
      if (accept) begin
         is_wr_d = |we;
         be_d    = we;
         haddr_d = addr[ADDR_WIDTH-2:0];
         wdata_d = wdata;
      end
      need_lo = !is_wr_d || (|be_d[1:0]);
      need_hi = !is_wr_d || (|be_d[3:2]);

      state_d = state_q;
      wcnt_d  = '0;
      case (state_q)
         IDLE:     if (accept) state_d = need_lo ? SETUP_LO : SETUP_HI;
         SETUP_LO: state_d = ACC_LO;
         ACC_LO: begin
            if (acc_last) state_d = need_hi ? SETUP_HI : DONE;
            else          wcnt_d  = wcnt_q + 1'b1;
         end
         SETUP_HI: state_d = ACC_HI;
         ACC_HI: begin
            if (acc_last) state_d = DONE;
            else          wcnt_d  = wcnt_q + 1'b1;
         end
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase

      // Read data is taken on the final access cycle, while oe_n has been low longest.
      rdata_d = rdata_q;
      if (!is_wr_q && acc_last) begin
         if (state_q == ACC_LO) rdata_d[15:0]  = sram_din;
         if (state_q == ACC_HI) rdata_d[31:16] = sram_din;
      end

      // Pin values are decoded from the next state so they line up with it.
      lo_ph  = (state_d == SETUP_LO) || (state_d == ACC_LO);
      hi_ph  = (state_d == SETUP_HI) || (state_d == ACC_HI);
      acc_ph = (state_d == ACC_LO) || (state_d == ACC_HI);
      active = lo_ph || hi_ph;

      ready_d     = (state_d == DONE);
      ce_n_d      = !active;
      oe_n_d      = !(acc_ph && !is_wr_d);
      we_n_d      = !(acc_ph && is_wr_d);
      doe_d       = active && is_wr_d;
      sram_addr_d = sram_addr_q;
      dout_d      = dout_q;
      lb_n_d      = 1'b1;
      ub_n_d      = 1'b1;
      if (active) begin
         sram_addr_d = {haddr_d, hi_ph};
         if (is_wr_d) begin
            lb_n_d = hi_ph ? !be_d[2] : !be_d[0];
            ub_n_d = hi_ph ? !be_d[3] : !be_d[1];
            dout_d = hi_ph ? wdata_d[31:16] : wdata_d[15:0];
         end else begin
            lb_n_d = 1'b0;
            ub_n_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wcnt_q      <= '0;
         rdata_q     <= '0;
         ready_q     <= 1'b0;
         sram_addr_q <= '0;
         dout_q      <= '0;
         doe_q       <= 1'b0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         lb_n_q      <= 1'b1;
         ub_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         rdata_q     <= rdata_d;
         ready_q     <= ready_d;
         sram_addr_q <= sram_addr_d;
         dout_q      <= dout_d;
         doe_q       <= doe_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         lb_n_q      <= lb_n_d;
         ub_n_q      <= ub_n_d;
      end
   end

   // Captured request context is only consulted outside IDLE, so it needs no reset.
   always_ff @(posedge clk) begin
      is_wr_q <= is_wr_d;
      be_q    <= be_d;
      haddr_q <= haddr_d;
      wdata_q <= wdata_d;
   end

   assign rdata     = rdata_q;
   assign mem_ready = ready_q;
   assign sram_addr = sram_addr_q;
   assign sram_dout = dout_q;
   assign sram_doe  = doe_q;
   assign sram_ce_n = ce_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_we_n = we_n_q;
   assign sram_lb_n = lb_n_q;
   assign sram_ub_n = ub_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: one instance with WAIT_CYCLES=1 and one with WAIT_CYCLES=3, each on its own
// behavioural asynchronous SRAM, checked against a word-level memory model.
module tb_sram_ctrl;
   localparam int AW = 10;
   localparam int HW = 1 << AW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst       [2];
   logic          re        [2];
   logic [3:0]    we        [2];
   logic [29:0]   addr      [2];
   logic [31:0]   wdata     [2];
   logic [31:0]   rdata     [2];
   logic          mem_ready [2];
   logic [AW-1:0] sram_addr [2];
   logic [15:0]   sram_dout [2];
   logic [15:0]   sram_din  [2];
   logic          sram_doe  [2];
   logic          ce_n      [2];
   logic          oe_n      [2];
   logic          we_n      [2];
   logic          lb_n      [2];
   logic          ub_n      [2];

   logic [15:0]   smem    [2][HW];
   logic [15:0]   ref_mem [2][HW];
   logic [31:0]   last_rd [2];

   int n_cmp = 0;
   int n_fail = 0;
   int ovl_cnt [2];
   int setup_err [2];
   int rdy_cnt [2];
   logic          p_ce_n [2];
   logic [AW-1:0] p_addr [2];
   bit model_en = 1'b0;

   sram_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) dut_w1 (
      .clk(clk), .reset(rst[0]), .re(re[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
      .rdata(rdata[0]), .mem_ready(mem_ready[0]), .sram_addr(sram_addr[0]), .sram_dout(sram_dout[0]),
      .sram_doe(sram_doe[0]), .sram_din(sram_din[0]), .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]),
      .sram_we_n(we_n[0]), .sram_lb_n(lb_n[0]), .sram_ub_n(ub_n[0]));

   sram_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(3)) dut_w3 (
      .clk(clk), .reset(rst[1]), .re(re[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
      .rdata(rdata[1]), .mem_ready(mem_ready[1]), .sram_addr(sram_addr[1]), .sram_dout(sram_dout[1]),
      .sram_doe(sram_doe[1]), .sram_din(sram_din[1]), .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]),
      .sram_we_n(we_n[1]), .sram_lb_n(lb_n[1]), .sram_ub_n(ub_n[1]));

   // The SRAM only drives its pins while selected and output-enabled; otherwise junk is seen.
   assign sram_din[0] = (!ce_n[0] && !oe_n[0]) ? smem[0][sram_addr[0]] : 16'h0BAD;
   assign sram_din[1] = (!ce_n[1] && !oe_n[1]) ? smem[1][sram_addr[1]] : 16'h0BAD;

   initial forever begin
      @(posedge clk);
      if (model_en) begin
         for (int i = 0; i < 2; i++) begin
            if (!ce_n[i] && !we_n[i]) begin
               if (!lb_n[i]) smem[i][sram_addr[i]][7:0]  = sram_doe[i] ? sram_dout[i][7:0]  : 8'hE0;
               if (!ub_n[i]) smem[i][sram_addr[i]][15:8] = sram_doe[i] ? sram_dout[i][15:8] : 8'hE0;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (model_en) begin
         for (int i = 0; i < 2; i++) begin
            if (sram_doe[i] && !oe_n[i]) ovl_cnt[i]++;
            if ((!we_n[i] || !oe_n[i]) && (ce_n[i] || p_ce_n[i] || (p_addr[i] != sram_addr[i])))
               setup_err[i]++;
            if (mem_ready[i]) rdy_cnt[i]++;
            p_ce_n[i] = ce_n[i];
            p_addr[i] = sram_addr[i];
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_read(input int i, input logic [29:0] a);
      logic [AW-1:0] h;
      h = {a[AW-2:0], 1'b0};
      return {ref_mem[i][h | AW'(1)], ref_mem[i][h]};
   endfunction

   task automatic ref_apply(input int i, input logic [3:0] w, input logic [29:0] a, input logic [31:0] d);
      logic [AW-1:0] h;
      if (w == 4'h0) begin
         last_rd[i] = ref_read(i, a);
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (w[b]) begin
               h = {a[AW-2:0], (b >= 2)};
               ref_mem[i][h][8*(b%2) +: 8] = d[8*b +: 8];
            end
         end
      end
   endtask

   // Present one request at a negedge, then follow it to its mem_ready pulse.
   task automatic xact(input int i, input logic r, input logic [3:0] w, input logic [29:0] a,
                       input logic [31:0] d, input int exp_lat, input logic [31:0] exp_rd, input string nm);
      int wc;
      int lat;
      logic wr, run_lo, run_hi, tr_ok;
      logic [AW-1:0] hb;
      logic [15:0] got_q[$];
      logic [15:0] exp_q[$];
      wc     = (i == 0) ? 1 : 3;
      wr     = |w;
      run_lo = !wr || (|w[1:0]);
      run_hi = !wr || (|w[3:2]);
      hb     = {a[AW-2:0], 1'b0};
      for (int p = 0; p < 2; p++) begin
         if ((p == 0) ? run_lo : run_hi) begin
            for (int k = 0; k < wc; k++)
               exp_q.push_back({3'b000, hb | AW'(p), wr ? !w[2*p] : 1'b0, wr ? !w[2*p+1] : 1'b0, wr});
         end
      end
      re[i] = r; we[i] = w; addr[i] = a; wdata[i] = d;
      @(negedge clk);
      re[i] = 1'b0; we[i] = 4'h0; addr[i] = 30'($urandom); wdata[i] = $urandom;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         if (!we_n[i] || !oe_n[i]) got_q.push_back({3'b000, sram_addr[i], lb_n[i], ub_n[i], !we_n[i]});
         if (mem_ready[i]) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      chk({nm, ":latency"}, 64'(lat), 64'(exp_lat));
      chk({nm, ":rdata"}, 64'(rdata[i]), 64'(exp_rd));
      tr_ok = (got_q.size() == exp_q.size());
      if (tr_ok) foreach (got_q[k]) if (got_q[k] !== exp_q[k]) tr_ok = 1'b0;
      chk({nm, ":strobe_trace_ok"}, 64'(tr_ok), 64'(1));
      @(negedge clk);
      chk({nm, ":ready_single_cycle"}, 64'(mem_ready[i]), 64'(0));
   endtask

   task automatic chk_reset(input int i, input string nm);
      chk({nm, ":rdata"}, 64'(rdata[i]), 64'(0));
      chk({nm, ":strobes"}, 64'({mem_ready[i], sram_doe[i], ce_n[i], oe_n[i], we_n[i], lb_n[i], ub_n[i]}),
          64'(7'b0011111));
      chk({nm, ":addr_dout"}, 64'({sram_addr[i], sram_dout[i]}), 64'(0));
   endtask

   typedef struct {
      logic        r;
      logic [3:0]  w;
      logic [29:0] a;
      logic [31:0] d;
      int          lat;
      logic [31:0] rd;
      logic [AW-1:0] ha;
      logic [15:0] hv;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int r0;
      int bad;
      logic found;
      logic r;
      logic [3:0] w;
      logic [29:0] a;
      logic [31:0] d;
      logic [31:0] erd;
      int elat;
      int wc;

      tbl[0]  = '{1'b1, 4'h0, 30'h005, 32'h00000000, 5, 32'h12345678, 10'h00A, 16'h5678};
      tbl[1]  = '{1'b0, 4'hF, 30'h003, 32'hDEADBEEF, 5, 32'h12345678, 10'h007, 16'hDEAD};
      tbl[2]  = '{1'b1, 4'h0, 30'h003, 32'h00000000, 5, 32'hDEADBEEF, 10'h006, 16'hBEEF};
      tbl[3]  = '{1'b0, 4'h4, 30'h003, 32'h00AB0000, 3, 32'hDEADBEEF, 10'h007, 16'hDEAB};
      tbl[4]  = '{1'b1, 4'h0, 30'h003, 32'h00000000, 5, 32'hDEABBEEF, 10'h007, 16'hDEAB};
      tbl[5]  = '{1'b0, 4'h1, 30'h003, 32'h000000CC, 3, 32'hDEABBEEF, 10'h006, 16'hBECC};
      tbl[6]  = '{1'b1, 4'h0, 30'h003, 32'h00000000, 5, 32'hDEABBECC, 10'h006, 16'hBECC};
      tbl[7]  = '{1'b0, 4'h3, 30'h203, 32'h11112222, 3, 32'hDEABBECC, 10'h006, 16'h2222};
      tbl[8]  = '{1'b1, 4'h0, 30'h003, 32'h00000000, 5, 32'hDEAB2222, 10'h007, 16'hDEAB};
      tbl[9]  = '{1'b0, 4'hA, 30'h005, 32'hAA00BB00, 5, 32'hDEAB2222, 10'h00B, 16'hAA34};
      tbl[10] = '{1'b1, 4'h0, 30'h005, 32'h00000000, 5, 32'hAA34BB78, 10'h00A, 16'hBB78};
      tbl[11] = '{1'b1, 4'h1, 30'h005, 32'h000000EE, 3, 32'hAA34BB78, 10'h00A, 16'hBBEE};
      tbl[12] = '{1'b1, 4'h0, 30'h005, 32'h00000000, 5, 32'hAA34BBEE, 10'h00B, 16'hAA34};

      for (int i = 0; i < 2; i++) begin
         for (int h = 0; h < HW; h++) smem[i][h] = 16'($urandom);
         rst[i] = 1'b1; re[i] = 1'b0; we[i] = 4'h0; addr[i] = '0; wdata[i] = '0;
         last_rd[i] = '0; ovl_cnt[i] = 0; setup_err[i] = 0; rdy_cnt[i] = 0; p_ce_n[i] = 1'b1; p_addr[i] = '0;
      end
      smem[0][10'h00A] = 16'h5678;
      smem[0][10'h00B] = 16'h1234;
      for (int i = 0; i < 2; i++) for (int h = 0; h < HW; h++) ref_mem[i][h] = smem[i][h];

      repeat (3) @(negedge clk);
      chk_reset(0, "reset_w1");
      chk_reset(1, "reset_w3");
      rst[0] = 1'b0; rst[1] = 1'b0;
      model_en = 1'b1;

      for (int v = 0; v < 13; v++) begin
         xact(0, tbl[v].r, tbl[v].w, tbl[v].a, tbl[v].d, tbl[v].lat, tbl[v].rd, $sformatf("vec%0d", v));
         ref_apply(0, tbl[v].w, tbl[v].a, tbl[v].d);
         chk($sformatf("vec%0d:sram_word", v), 64'(smem[0][tbl[v].ha]), 64'(tbl[v].hv));
      end

      // Reset while idle with non-zero rdata and a stale address on the pins.
      rst[0] = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset(0, "idle_reset");
      rst[0] = 1'b0;
      last_rd[0] = '0;
      r0 = rdy_cnt[0];
      repeat (10) @(negedge clk);
      chk("idle_reset:no_ready", 64'(rdy_cnt[0] - r0), 64'(0));

      // Back-to-back read then write on the slow instance.
      r0 = rdy_cnt[1];
      ref_mem[1][10'h010] = smem[1][10'h010];
      xact(1, 1'b1, 4'h0, 30'h008, 32'h0, 9, ref_read(1, 30'h008), "b2b_read");
      ref_apply(1, 4'h0, 30'h008, 32'h0);
      xact(1, 1'b0, 4'hF, 30'h009, 32'h89ABCDEF, 9, last_rd[1], "b2b_write");
      ref_apply(1, 4'hF, 30'h009, 32'h89ABCDEF);
      chk("b2b:ready_count", 64'(rdy_cnt[1] - r0), 64'(2));
      chk("b2b:sram_hi", 64'(smem[1][10'h013]), 64'(16'h89AB));

      // Abort a full write during its high access phase.
      we[1] = 4'hF; addr[1] = 30'h020; wdata[1] = 32'hCAFEF00D;
      @(negedge clk);
      we[1] = 4'h0;
      found = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (!we_n[1] && sram_addr[1][0]) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("rst_mid:reached_acc_hi", 64'(found), 64'(1));
      r0 = rdy_cnt[1];
      rst[1] = 1'b1;
      @(negedge clk);
      chk("rst_mid:strobes", 64'({we_n[1], sram_doe[1], ce_n[1], oe_n[1]}), 64'(4'b1011));
      rst[1] = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_mid:no_ready", 64'(rdy_cnt[1] - r0), 64'(0));
      chk("rst_mid:low_half_written", 64'(smem[1][10'h040]), 64'(16'hF00D));
      ref_mem[1][10'h040] = smem[1][10'h040];
      ref_mem[1][10'h041] = smem[1][10'h041];
      last_rd[1] = '0;
      xact(1, 1'b1, 4'h0, 30'h020, 32'h0, 9, ref_read(1, 30'h020), "rst_mid:read_after");
      ref_apply(1, 4'h0, 30'h020, 32'h0);

      // Randomised traffic against the word-level model, back-to-back on each instance.
      for (int i = 0; i < 2; i++) begin
         wc = (i == 0) ? 1 : 3;
         for (int n = 0; n < ((i == 0) ? 60 : 30); n++) begin
            w = 4'($urandom_range(0, 15));
            r = 1'($urandom_range(0, 1));
            if (w == 4'h0) r = 1'b1;
            if ($urandom_range(0, 2) == 0) w = 4'h0;
            if (w == 4'h0) r = 1'b1;
            a = (30'($urandom) & 30'h3FFF_FE00) | 30'($urandom_range(0, 15));
            d = $urandom;
            erd  = (w != 4'h0) ? last_rd[i] : ref_read(i, a);
            elat = ((w == 4'h0) || ((|w[1:0]) && (|w[3:2]))) ? 2*wc + 3 : wc + 2;
            xact(i, r, w, a, d, elat, erd, $sformatf("rnd_w%0d_%0d", wc, n));
            ref_apply(i, w, a, d);
         end
      end

      bad = 0;
      for (int i = 0; i < 2; i++) for (int h = 0; h < HW; h++) if (smem[i][h] !== ref_mem[i][h]) bad++;
      chk("final:memory_diff_count", 64'(bad), 64'(0));
      chk("final:doe_oe_overlap", 64'(ovl_cnt[0] + ovl_cnt[1]), 64'(0));
      chk("final:setup_violations", 64'(setup_err[0] + setup_err[1]), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
